bcd_display_sequencer: RTL and testbench

//   Time-shares ONE bcd_to_seven_seg decoder across NUM_DIGITS HEX displays.

---
 rtl/display_pkg.sv | 24 ++
 rtl/bcd_to_seven_seg.sv | 29 ++
 rtl/bcd_display_sequencer.sv | 144 ++++++++++++++
 tb/tb_bcd_display_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and state type for the HEX display sequencing path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package display_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    COMMIT
  } seq_state_t;

  // True when a nibble is a legal decimal digit.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Purpose: decode one BCD digit to an active-low seven-segment pattern.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input; non-decimal codes show blank.
module bcd_to_seven_seg
  import display_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd_val,
  output logic [SEG_W-1:0]   seven_seg_val
);

  // Digit lookup; the caller decides how to present codes above 9.
  always_comb begin
    seven_seg_val = SEG_BLANK;
    case (bcd_val)
      4'd0:    seven_seg_val = 7'b1000000;
      4'd1:    seven_seg_val = 7'b1111001;
      4'd2:    seven_seg_val = 7'b0100100;
      4'd3:    seven_seg_val = 7'b0110000;
      4'd4:    seven_seg_val = 7'b0011001;
      4'd5:    seven_seg_val = 7'b0010010;
      4'd6:    seven_seg_val = 7'b0000010;
      4'd7:    seven_seg_val = 7'b1111000;
      4'd8:    seven_seg_val = 7'b0000000;
      4'd9:    seven_seg_val = 7'b0010000;
      default: seven_seg_val = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_sequencer.sv
// Purpose: time-share one BCD decoder over NUM_DIGITS displays via a shadow bank,
//   committed atomically (optional LEADING_ZERO_BLANK_EN blanks leading zeros).
// Latency: accept at edge T -> HEX updates at edge T+NUM_DIGITS+1; ready drops while busy.
module bcd_display_sequencer
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_bcd,
  output logic [SEG_W*NUM_DIGITS-1:0]   HEX,
  output logic                          busy,
  output logic                          bcd_err
);

  // Index width kept at least one bit so NUM_DIGITS = 1 still elaborates.
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  seq_state_t                           state_q;
  seq_state_t                           state_nxt;
  logic [IDX_W-1:0]                     idx_q;
  logic [DIGIT_W*NUM_DIGITS-1:0]        word_q;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]     shadow_q;
  logic                                 err_pend_q;
  logic                                 accept;
  logic [DIGIT_W-1:0]                   cur_nib;
  logic [SEG_W-1:0]                     dec_seg;
  logic [SEG_W-1:0]                     seg_sel;
  logic                                 blank_digit;

  assign accept = load_valid && load_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and handshake outputs; busy covers DECODE and COMMIT.
  always_comb begin
    state_nxt  = state_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nxt = DECODE;
      end
      DECODE: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_nxt = COMMIT;
      end
      COMMIT: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the nibble currently being decoded from the captured word.
  always_comb begin
    cur_nib = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_nib = word_q[DIGIT_W*i +: DIGIT_W];
    end
  end

  bcd_to_seven_seg u_dec (
    .bcd_val       (cur_nib),
    .seven_seg_val (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Current digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx_q) && (word_q[DIGIT_W*i +: DIGIT_W] != '0)) upper_zero = 1'b0;
    end
  end

  // Digit 0 always shows, so an all-zero word displays a single "0".
  assign blank_digit = upper_zero && (idx_q != '0);
`else
  assign blank_digit = 1'b0;
`endif

  // Pattern written into the shadow bank for the current digit.
  always_comb begin
    if (blank_digit) begin
      seg_sel = SEG_BLANK;
    end else if (!is_bcd(cur_nib)) begin
      seg_sel = SEG_DASH;
    end else begin
      seg_sel = dec_seg;
    end
  end

  // Datapath: capture, per-digit shadow writes, and the single-cycle commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      word_q     <= '0;
      shadow_q   <= {NUM_DIGITS{SEG_BLANK}};
      err_pend_q <= 1'b0;
      HEX        <= {NUM_DIGITS{SEG_BLANK}};
      bcd_err    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            word_q <= load_bcd;
            idx_q  <= '0;
          end
        end
        DECODE: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) shadow_q[i] <= seg_sel;
          end
          if (!is_bcd(cur_nib)) err_pend_q <= 1'b1;
          // Index saturates at the last digit rather than wrapping.
          if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
        end
        COMMIT: begin
          HEX        <= shadow_q;
          bcd_err    <= err_pend_q;
          err_pend_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Purpose: scoreboard bench for bcd_display_sequencer against an arithmetic display model.
// Latency: checks accept-to-commit distance of NUM_DIGITS+1 edges.
// Backpressure: producer waits for load_ready; HEX/ready watched while busy.
module tb_bcd_display_sequencer;

  localparam int N = 6;
  localparam int W = 4 * N;
  localparam logic [7*N-1:0] ALL_BLANK = {N{7'h7F}};

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           load_valid = 1'b0;
  logic [W-1:0]   load_bcd = '0;
  logic           load_ready;
  logic [7*N-1:0] HEX;
  logic           busy;
  logic           bcd_err;

  bcd_display_sequencer #(.NUM_DIGITS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_bcd   (load_bcd),
    .HEX        (HEX),
    .busy       (busy),
    .bcd_err    (bcd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7*N-1:0] hex;
    logic           err;
    int             acc_cyc;
  } exp_t;

  exp_t           sb[$];
  int             n_chk = 0;
  int             n_fail = 0;
  int             cyc = 0;
  logic [7*N-1:0] cur_hex = ALL_BLANK;
  logic           prev_busy = 1'b0;
  logic [6:0]     seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Display contents the word should produce, from the digit rules directly.
  function automatic exp_t model(input logic [W-1:0] w);
    exp_t e;
    logic [W-1:0] sh;
    int nib;
    e.hex = '0;
    e.err = 1'b0;
    e.acc_cyc = 0;
    for (int i = 0; i < N; i++) begin
      sh  = w >> (4 * i);
      nib = int'(sh[3:0]);
      if (nib > 9) begin
        e.hex[7*i +: 7] = 7'b0111111;
        e.err = 1'b1;
      end else begin
        e.hex[7*i +: 7] = seg_tab[nib];
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && sh == '0) e.hex[7*i +: 7] = 7'h7F;
`endif
    end
    return e;
  endfunction

  // Monitor: HEX must hold while busy; each busy->idle transition is a commit.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        check("hex_hold_while_busy", HEX, cur_hex);
        check("ready_low_while_busy", load_ready, 0);
      end
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_commit: got HEX %0h, expected no commit", HEX);
        end else begin
          e = sb.pop_front();
          check("commit_hex", HEX, e.hex);
          check("commit_err", bcd_err, e.err);
          check("commit_latency", cyc - e.acc_cyc, N + 1);
          cur_hex = e.hex;
        end
      end
      prev_busy = busy;
    end
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 99) < 88) w[4*i +: 4] = 4'($urandom_range(0, 9));
      else                            w[4*i +: 4] = 4'($urandom_range(10, 15));
    end
    if ($urandom_range(0, 3) == 0) w = w >> (4 * $urandom_range(1, N - 1));
    return w;
  endfunction

  // Present a word once ready; optionally keep valid high with changing data afterwards.
  task automatic send(input logic [W-1:0] w, input int hold);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!load_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!load_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got load_ready 0, expected 1 within 100 cycles");
      return;
    end
    load_valid = 1'b1;
    load_bcd   = w;
    e = model(w);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    for (int k = 0; k < hold; k++) begin
      load_bcd = rand_word();
      @(posedge clk);
      #1;
    end
    load_valid = 1'b0;
    load_bcd   = rand_word();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_hex", HEX, ALL_BLANK);
    check("reset_ready", load_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_err", bcd_err, 0);

    send(24'h123456, 0);
    drain();
    check("hex0_is_6", HEX[6:0], 7'b0000010);
    check("hex5_is_1", HEX[41:35], 7'b1111001);

    send(24'h000042, 0);
    drain();
    send(24'h000000, 0);
    drain();
    check("zero_digit0", HEX[6:0], 7'b1000000);

    send(24'h12A456, 0);
    drain();
    check("dash_digit3", HEX[27:21], 7'b0111111);
    check("err_set", bcd_err, 1);
    send(24'h000001, 0);
    drain();
    check("err_cleared", bcd_err, 0);

    // Valid held through the busy window with changing data.
    send(24'h987650, N - 1);
    drain();

    // Back-to-back random traffic.
    for (int i = 0; i < 25; i++) send(rand_word(), $urandom_range(0, N - 1));
    drain();

    // Reset in the middle of a decode.
    send(24'h246813, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midreset_hex", HEX, ALL_BLANK);
    check("midreset_busy", busy, 0);
    #2 rst_n = 1'b1;
    cur_hex = ALL_BLANK;
    @(negedge clk);
    check("postreset_ready", load_ready, 1);
    check("postreset_hex", HEX, ALL_BLANK);
    check("postreset_err", bcd_err, 0);
    send(24'h135790, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected finish before 300000");
    $fatal(1, "watchdog expired");
  end

endmodule
